i2c_seg_mux_controller: RTL
===========================

# i2c_seg_mux_controller

Write-only I2C target that receives per-digit segment patterns and drives a time-multiplexed common-cathode 7-segment display of `NUM_DIGITS` digits. It sits directly behind the chip top: SCL/SDA come in on bidirectional pins, and segment and digit-select lines go out on the dedicated outputs. It is the parametrised successor of the single-digit static segment top, adding a bus protocol, digit storage, auto-incrementing addressing and refresh multiplexing.

## Interface
Parameters
- `I2C_ADDR`, 7'h42: 7-bit target address matched on the bus.
- `NUM_DIGITS`, 4: number of digits; legal range 1–8.
- `REFRESH_DIV`, 24'd10_000: clk cycles each digit stays selected; legal range ≥ 2.

Ports
- `clk`, in, 1: single system clock; all logic is in this domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `scl_in`, in, 1: raw SCL pin level.
- `sda_in`, in, 1: raw SDA pin level.
- `sda_oe`, out, 1: 1 drives SDA low (open-drain); `sda_out` is tied 0 at the top.
- `seg_out`, out, 7: segments a..g (bit0 = a), active-high, for the currently selected digit.
- `dp_out`, out, 1: decimal point of the selected digit, active-high.
- `dig_sel`, out, `NUM_DIGITS`: one-hot digit enable, active-high.
- `busy`, out, 1: 1 while a transaction addressed to this target is in progress.

## Operation
- Input conditioning
  - SCL and SDA each pass through a 2-FF synchroniser, then a registered edge detector.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Protocol FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB-first on SCL rising edges.
    - Address matches and R/W=0 → ADDR_ACK.
    - Otherwise → IGNORE, with no ACK.
  - ADDR_ACK → PTR.
  - PTR: receive 8 bits.
    - Value < `NUM_DIGITS` → load the pointer, then PTR_ACK.
    - Otherwise → NACK (SDA released) and go to IGNORE.
  - PTR_ACK → DATA.
  - DATA: receive 8 bits, then DATA_ACK, which writes the digit register and advances the pointer.
    - Pointer wraps from `NUM_DIGITS`-1 to 0.
    - DATA_ACK → DATA, so writes repeat without limit.
  - IGNORE: no SDA activity until STOP or START.
  - From any state: START (including repeated START) → ADDR; STOP → IDLE.
- Digit register: 8 bits per digit, written with the received byte. Bit7 = DP; bits 6:0 are interpreted per Configuration.
- Display
  - A refresh counter counts 0..`REFRESH_DIV`-1.
  - At the terminal count, the digit index advances and wraps from `NUM_DIGITS`-1 to 0.
  - `seg_out`, `dp_out` and `dig_sel` are registered from the current index.
  - Register writes never stall the refresh; a write to the displayed digit appears on the next index change or immediately, whichever comes first (outputs are re-registered every cycle).
- `busy` = 1 in states ADDR_ACK through DATA_ACK; 0 in IDLE, ADDR and IGNORE.

## Timing
- Reset values (asynchronous assert)
  - FSM in IDLE; `sda_oe`=0; all digit registers 0; pointer 0; refresh counter 0; index 0.
  - Outputs: `seg_out`=0, `dp_out`=0, `dig_sel`=one-hot bit0, `busy`=0.
- Latency from pin edge to internal event: 3 clk (2 sync + 1 edge register). The bus must have SCL high/low phases ≥ 8 clk.
- ACK timing
  - `sda_oe` asserts 1 clk after the detected SCL falling edge that follows the 8th bit.
  - It deasserts 1 clk after the next detected SCL falling edge.
- The digit register updates in the same cycle `sda_oe` asserts for the data ACK.
- Digit period: exactly `REFRESH_DIV` clk per digit; a full frame is `NUM_DIGITS`×`REFRESH_DIV` clk.
- Reset mid-transaction: `sda_oe` drops immediately and any partially received byte is discarded. After release, the FSM waits in IDLE for a new START.
- START and STOP detected while a bit is mid-shift abort that byte; no register is written.

## Configuration
- `HEX_DECODE_EN`
  - Defined: bits 3:0 of each digit register pass through a hex-to-7-segment decoder (0–F, standard glyphs; e.g. 0 → 7'h3F, 8 → 7'h7F, A → 7'h77). Bits 6:4 are ignored.
  - Undefined: bits 6:0 drive `seg_out` raw.
  - Bit7 is always DP.

## Test plan
- Reset: hold `rst_n`=0 → `seg_out`=0, `dig_sel`=4'b0001, `sda_oe`=0, `busy`=0. After release, `dig_sel` rotates 0001→0010→0100→1000→0001, each step every `REFRESH_DIV` clk.
- Write addr 0x42/W, ptr 0x01, data 0x86 → ACK on all three bytes. When `dig_sel`=0010: raw mode gives `seg_out`=7'h06, `dp_out`=1; with `HEX_DECODE_EN` it gives `seg_out`=7'h7D (digit 6), `dp_out`=1.
- Auto-increment wrap: ptr 0x03, data 0x3F, 0x06, 0x5B → digits 3, 0, 1 are written; digit 2 is unchanged.
- Wrong address 0x21, and addr 0x42 with R/W=1 → no ACK, `busy` stays 0, no register changes.
- Pointer 0x04 with `NUM_DIGITS`=4 → pointer byte NACKed, following data ignored, digits unchanged. A repeated START then addr 0x42/W, ptr 0, data 0x7F → digit 0 = 0x7F.
- `rst_n` pulsed low during the 5th data bit → `sda_oe`=0 immediately, all digits 0. The next full transaction succeeds.

Source files
------------

// File: rtl/i2c_seg_mux_controller.sv
// rtl/i2c_seg_mux_controller.sv - write-only I2C target driving a multiplexed 7-segment display
// Optional feature macro: HEX_DECODE_EN (hex-to-7-segment decode of digit bits 3:0)
module i2c_seg_mux_controller #(
    parameter logic [6:0]  I2C_ADDR    = 7'h42,
    parameter int          NUM_DIGITS  = 4,
    parameter logic [23:0] REFRESH_DIV = 24'd10_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  busy
);
    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [1:0]  warm_q, warm_d;
    logic        ev_ok;
    logic        scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic        start_q, start_d, stop_q, stop_d;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic        oe_q, oe_d;
    logic [7:0]  dig_q [NUM_DIGITS];
    logic [7:0]  dig_d [NUM_DIGITS];
    logic [23:0] cnt_q, cnt_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [7:0]  cur;

`ifdef HEX_DECODE_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction
`endif

    // Edge flags stay quiet until the sync chain holds real pin levels, so reset
    // release in the middle of a bus transfer cannot fake a START or STOP.
    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
        warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        ev_ok      = (warm_q == 2'd3);
        scl_rise_d = ev_ok &  scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall_d = ev_ok & ~scl_sync_q[1] &  scl_sync_q[2];
        start_d    = ev_ok & scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
        stop_d     = ev_ok & scl_sync_q[1] & scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        dig_d     = dig_q;
        if (stop_q) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else if (start_q) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_DATA: begin
                    if (scl_rise_q && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_sync_q[2]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_IGNORE;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == I2C_ADDR && !shift_q[0]) begin
                                state_d = S_ADDR_ACK;
                                oe_d    = 1'b1;
                            end
                        end else if (state_q == S_PTR) begin
                            if (int'(shift_q) < NUM_DIGITS) begin
                                ptr_d   = shift_q[PW-1:0];
                                state_d = S_PTR_ACK;
                                oe_d    = 1'b1;
                            end
                        end else begin
                            dig_d[ptr_q] = shift_q;
                            ptr_d   = (ptr_q == PW'(NUM_DIGITS - 1)) ? '0 : ptr_q + PW'(1);
                            state_d = S_DATA_ACK;
                            oe_d    = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_DATA_ACK: begin
                    if (scl_fall_q) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = (state_q == S_ADDR_ACK) ? S_PTR : S_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d     = (cnt_q == REFRESH_DIV - 24'd1) ? 24'd0 : cnt_q + 24'd1;
        idx_d     = idx_q;
        if (cnt_q == REFRESH_DIV - 24'd1)
            idx_d = (idx_q == PW'(NUM_DIGITS - 1)) ? '0 : idx_q + PW'(1);
        cur       = dig_q[idx_q];
`ifdef HEX_DECODE_EN
        seg_d     = hex7(cur[3:0]);
`else
        seg_d     = cur[6:0];
`endif
        dp_d      = cur[7];
        dig_sel_d = '0;
        dig_sel_d[idx_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            warm_q     <= '0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            dig_sel_q  <= NUM_DIGITS'(1);
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            warm_q     <= warm_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign sda_oe  = oe_q;
    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign dig_sel = dig_sel_q;
    assign busy    = (state_q == S_ADDR_ACK) || (state_q == S_PTR) || (state_q == S_PTR_ACK) ||
                     (state_q == S_DATA) || (state_q == S_DATA_ACK);
endmodule
